blinkt_frame_gen: RTL and testbench

BLINKT_FRAME_GEN -- requirements
Module: blinkt_frame_gen

---
 rtl/blinkt_frame_gen_if.sv | 9 +
 rtl/blinkt_frame_gen.sv | 145 ++++++++++++++
 tb/tb_blinkt_frame_gen.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/blinkt_frame_gen_if.sv
// AXIS word stream from the Blinkt framer to the APA102 serializer.
interface blinkt_frame_gen_if;
    logic [31:0] m_axis_data;
    logic        m_axis_tvalid;
    logic        m_axis_tready;

    modport master (output m_axis_data, output m_axis_tvalid, input m_axis_tready);
    modport slave  (input m_axis_data, input m_axis_tvalid, output m_axis_tready);
endinterface

// File: rtl/blinkt_frame_gen.sv
// Blinkt/APA102 refresh framer: snapshots the live LED bank, then streams start, LED and end words.
// Start word appears two cycles after an idle update; words are registered and held until tready.
module blinkt_frame_gen #(
    parameter int NUM_LEDS  = 8,
    parameter int END_WORDS = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_wr_en,
    input  logic [4:0]         i_wr_addr,
    input  logic [31:0]        i_wr_data,
    input  logic               i_update,
    output logic               o_busy,
    blinkt_frame_gen_if.master axis
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_LED   = 3'd3,
        S_END   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        pending_q, pending_d;
    logic [31:0] data_q, data_d;
    logic        vld_q, vld_d;
    logic [28:0] live_q   [NUM_LEDS];
    logic [28:0] live_d   [NUM_LEDS];
    logic [28:0] shadow_q [NUM_LEDS];
    logic [28:0] shadow_d [NUM_LEDS];

    logic        hs;
    logic [4:0]  sel_idx;
    logic [28:0] sel_ent;
    logic [31:0] led_word;
    logic        unused_wr_bits;

    assign unused_wr_bits     = ^i_wr_data[31:29];
    assign hs                 = vld_q & axis.m_axis_tready;
    assign o_busy             = (state_q != S_IDLE);
    assign axis.m_axis_data   = data_q;
    assign axis.m_axis_tvalid = vld_q;

    // Word being loaded next: LED 0 when leaving START, otherwise the following LED.
    always_comb begin
        sel_idx = (state_q == S_START) ? 5'd0 : idx_q + 5'd1;
        sel_ent = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (sel_idx == 5'(i)) sel_ent = shadow_q[i];
        end
        led_word = {3'b111, sel_ent[28:24], sel_ent[7:0], sel_ent[15:8], sel_ent[23:16]};
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        data_d    = data_q;
        vld_d     = vld_q;
        live_d    = live_q;
        shadow_d  = shadow_q;

        for (int i = 0; i < NUM_LEDS; i++) begin
            if (i_wr_en && (i_wr_addr == 5'(i))) live_d[i] = i_wr_data[28:0];
        end
        if (state_q != S_IDLE && i_update) pending_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                vld_d = 1'b0;
                if (i_update) state_d = S_LOAD;
            end
            S_LOAD: begin
                shadow_d = live_q;
                data_d   = 32'h0000_0000;
                vld_d    = 1'b1;
                state_d  = S_START;
            end
            S_START: begin
                if (hs) begin
                    data_d  = led_word;
                    idx_d   = 5'd0;
                    state_d = S_LED;
                end
            end
            S_LED: begin
                if (hs) begin
                    if (idx_q == 5'(NUM_LEDS - 1)) begin
                        data_d  = 32'hFFFF_FFFF;
                        cnt_d   = 2'd0;
                        state_d = S_END;
                    end else begin
                        data_d = led_word;
                        idx_d  = idx_q + 5'd1;
                    end
                end
            end
            S_END: begin
                if (hs) begin
                    if (cnt_q == 2'(END_WORDS - 1)) begin
                        vld_d = 1'b0;
                        // A request on this very edge must not be dropped.
                        state_d = (pending_q || i_update) ? S_LOAD : S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                vld_d   = 1'b0;
            end
        endcase

        if (state_d == S_LOAD && state_q != S_LOAD) pending_d = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            data_q    <= '0;
            vld_q     <= 1'b0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                live_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            data_q    <= data_d;
            vld_q     <= vld_d;
            live_q    <= live_d;
            shadow_q  <= shadow_d;
        end
    end
endmodule

// File: tb/tb_blinkt_frame_gen.sv
// Bench for blinkt_frame_gen: random LED data and tready against a frame-level reference model.
module tb_blinkt_frame_gen;
    localparam int NL = 8;
    localparam int NE = 1;
    localparam int FW = 1 + NL + NE;

    logic        i_clk     = 1'b0;
    logic        i_reset   = 1'b1;
    logic        i_wr_en   = 1'b0;
    logic [4:0]  i_wr_addr = '0;
    logic [31:0] i_wr_data = '0;
    logic        i_update  = 1'b0;
    logic        o_busy;

    blinkt_frame_gen_if axis ();

    blinkt_frame_gen #(.NUM_LEDS(NL), .END_WORDS(NE)) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_wr_en   (i_wr_en),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .i_update  (i_update),
        .o_busy    (o_busy),
        .axis      (axis)
    );

    always #5 i_clk = ~i_clk;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic        rdy_rand = 1'b0;
    logic [28:0] live_m [NL];
    logic [31:0] exp_q [$];
    logic [31:0] cap_q [$];
    int          cap_cyc [$];
    logic [31:0] got_w [$];
    int          first_cyc, last_cyc, prev_last;
    logic        prev_vld = 1'b0, prev_rdy = 1'b0, prev_rst = 1'b1;
    logic [31:0] prev_data = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // APA102 word from a 29-bit LED setting: brightness, then blue, green, red.
    function automatic logic [31:0] apa(input logic [28:0] e);
        int bri, red, grn, blu;
        bri = int'(e) / (1 << 24);
        red = (int'(e) / (1 << 16)) % 256;
        grn = (int'(e) / (1 << 8)) % 256;
        blu = int'(e) % 256;
        return 32'hE000_0000 + 32'(bri * (1 << 24) + blu * (1 << 16) + grn * (1 << 8) + red);
    endfunction

    task automatic push_frame();
        exp_q.push_back(32'h0000_0000);
        for (int i = 0; i < NL; i++) exp_q.push_back(apa(live_m[i]));
        for (int i = 0; i < NE; i++) exp_q.push_back(32'hFFFF_FFFF);
    endtask

    task automatic model_wr(input logic [4:0] a, input logic [31:0] d);
        if (int'(a) < NL) live_m[a] = d[28:0];
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = d;
        model_wr(a, d);
        tick();
        i_wr_en = 1'b0;
    endtask

    // Update with a write in the same cycle (in snapshot) and one in the LOAD cycle (not in snapshot).
    task automatic refresh_w(input logic [4:0] a1, input logic [31:0] d1,
                             input logic [4:0] a2, input logic [31:0] d2);
        i_update = 1'b1; i_wr_en = 1'b1; i_wr_addr = a1; i_wr_data = d1;
        model_wr(a1, d1);
        push_frame();
        tick();
        i_update = 1'b0; i_wr_addr = a2; i_wr_data = d2;
        tick();
        model_wr(a2, d2);
        i_wr_en = 1'b0;
    endtask

    task automatic drain(input string tag, input int n);
        int budget;
        budget = 0;
        got_w.delete();
        while (cap_q.size() < n && budget < 3000) begin
            tick();
            budget++;
        end
        chk({tag, "_count"}, 32'(cap_q.size() >= n ? n : cap_q.size()), 32'(n));
        for (int k = 0; k < n; k++) begin
            if (cap_q.size() > 0 && exp_q.size() > 0) begin
                got_w.push_back(cap_q[0]);
                if (k == 0) first_cyc = cap_cyc[0];
                last_cyc = cap_cyc[0];
                void'(cap_cyc.pop_front());
                chk(tag, cap_q.pop_front(), exp_q.pop_front());
            end
        end
    endtask

    task automatic settle(input string tag);
        repeat (4) tick();
        chk({tag, "_idle_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_idle_vld"}, 32'(axis.m_axis_tvalid), 32'd0);
        chk({tag, "_no_extra"}, 32'(cap_q.size()), 32'd0);
    endtask

    always @(posedge i_clk) cyc++;

    // Record handshakes and check that an unaccepted word is held unchanged.
    always @(negedge i_clk) begin
        if (!i_reset && axis.m_axis_tvalid === 1'b1 && axis.m_axis_tready === 1'b1) begin
            cap_q.push_back(axis.m_axis_data);
            cap_cyc.push_back(cyc);
        end
        if (prev_vld === 1'b1 && prev_rdy === 1'b0 && prev_rst === 1'b0) begin
            chk("hold_vld", 32'(axis.m_axis_tvalid), 32'd1);
            chk("hold_data", axis.m_axis_data, prev_data);
        end
        prev_vld  = axis.m_axis_tvalid;
        prev_rdy  = axis.m_axis_tready;
        prev_data = axis.m_axis_data;
        prev_rst  = i_reset;
    end

    initial begin
        axis.m_axis_tready = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            axis.m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NL; i++) live_m[i] = '0;
        repeat (3) tick();
        @(negedge i_clk);
        chk("rst_vld", 32'(axis.m_axis_tvalid), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_data", axis.m_axis_data, 32'd0);
        tick();
        i_reset = 1'b0;
        tick();

        // Post-reset frame, tready held high: latency, contents and no bubbles.
        i_update = 1'b1;
        push_frame();
        tick();
        i_update = 1'b0;
        @(negedge i_clk);
        chk("load_busy", 32'(o_busy), 32'd1);
        chk("load_vld", 32'(axis.m_axis_tvalid), 32'd0);
        tick();
        @(negedge i_clk);
        chk("n2_vld", 32'(axis.m_axis_tvalid), 32'd1);
        chk("n2_data", axis.m_axis_data, 32'd0);
        chk("n2_busy", 32'(o_busy), 32'd1);
        drain("frame0", FW);
        chk("frame0_span", 32'(last_cyc - first_cyc), 32'(FW - 1));
        settle("frame0");

        do_write(5'd3, 32'h1F11_2233);
        refresh_w(5'd31, 32'h0, 5'd31, 32'h0);
        drain("led3", FW);
        chk("led3_word", got_w[4], 32'hFF33_2211);
        chk("led2_word", got_w[3], 32'hE000_0000);
        settle("led3");

        // Random data, random addresses (some out of range) and random tready.
        rdy_rand = 1'b1;
        for (int r = 0; r < 5; r++) begin
            repeat ($urandom_range(2, 6)) do_write(5'($urandom_range(0, 15)), $urandom);
            refresh_w(5'($urandom_range(0, NL - 1)), $urandom,
                      5'($urandom_range(0, NL - 1)), $urandom);
            drain("rnd", FW);
            settle("rnd");
        end

        // LOAD-cycle write lands only in the next refresh; addr 9 is ignored.
        refresh_w(5'd9, 32'h1234_5678, 5'd0, 32'h0500_0001);
        drain("ld_write_a", FW);
        settle("ld_write_a");
        refresh_w(5'd9, 32'hFFFF_FFFF, 5'd31, 32'h0);
        drain("ld_write_b", FW);
        chk("led0_next", got_w[1], 32'hE501_0000);
        settle("ld_write_b");

        // Several requests during one refresh collapse into a single extra refresh.
        i_update = 1'b1;
        push_frame();
        tick();
        i_update = 1'b0;
        repeat (3) begin
            tick();
            i_update = 1'b1;
            tick();
            i_update = 1'b0;
        end
        push_frame();
        drain("pend", 2 * FW);
        settle("pend");

        // Request on the final end-word handshake edge restarts with LOAD right after.
        rdy_rand = 1'b0;
        repeat (2) tick();
        i_update = 1'b1;
        push_frame();
        tick();
        i_update = 1'b0;
        repeat (10) tick();
        i_update = 1'b1;
        tick();
        i_update = 1'b0;
        push_frame();
        drain("fin_a", FW);
        chk("fin_a_span", 32'(last_cyc - first_cyc), 32'(FW - 1));
        prev_last = last_cyc;
        drain("fin_b", FW);
        chk("reload_gap", 32'(first_cyc - prev_last), 32'd2);
        settle("fin");

        // Reset while LED index 4 is on the bus.
        i_update = 1'b1;
        push_frame();
        tick();
        i_update = 1'b0;
        repeat (6) tick();
        i_reset = 1'b1;
        tick();
        @(negedge i_clk);
        chk("midrst_vld", 32'(axis.m_axis_tvalid), 32'd0);
        chk("midrst_busy", 32'(o_busy), 32'd0);
        chk("midrst_data", axis.m_axis_data, 32'd0);
        i_reset = 1'b0;
        for (int i = 0; i < NL; i++) live_m[i] = '0;
        drain("partial", 5);
        exp_q.delete();
        settle("partial");
        rdy_rand = 1'b1;
        refresh_w(5'd31, 32'h0, 5'd31, 32'h0);
        drain("fresh", FW);
        settle("fresh");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
